aes_round_tail: RTL and testbench
=================================

Name: aes_round_tail

Overview:
- Two-stage pipelined round back-end that consumes the 128-bit output of the 16-byte SubBytes array.
- Encrypt: ShiftRows, then MixColumns (skipped on the final round), then AddRoundKey.
- Decrypt: AddRoundKey, then InvMixColumns (skipped on the final round), then InvShiftRows.
- Valid/ready on both sides; the output feeds the round-state register or the SubBytes input of the next round.

Parameters:
- DW, 128, state/key width; fixed at 128, any other value is a configuration error.
- ZERO_DATA_ON_RESET, 1, when 1 the data registers clear on reset; when 0 only the control registers clear.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- sc  in  1  direction: 0 = encrypt, 1 = decrypt (same encoding as the SubBytes select)
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- in_data  in  128  SubBytes output; byte 0 = [127:120], column-major (byte k = row k%4, column k/4)
- in_key  in  128  round key, same byte order
- in_last  in  1  final round: skip (Inv)MixColumns
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  128  round result

Behaviour:
- Reset: s1_valid = s2_valid = 0; out_valid = 0; out_data = 0 when ZERO_DATA_ON_RESET = 1.
  - in_ready is combinational and reads 1 during and after reset.
  - Reset asserted mid-operation discards all in-flight beats; no partial output is presented.
- Beat transfer occurs on a clock edge where valid && ready.
- Stage 1 captures in_data, in_key, in_last and sc with the beat.
  - sc = 0: s1_data = ShiftRows(in_data).
  - sc = 1: s1_data = in_data ^ in_key.
- Stage 2 computes and registers the result.
  - sc = 0: out = (last ? s1_data : MixColumns(s1_data)) ^ s1_key.
  - sc = 1: out = InvShiftRows(last ? s1_data : InvMixColumns(s1_data)).
- ShiftRows moves row r left by r columns; InvShiftRows moves row r right by r columns.
- GF(2^8) arithmetic uses reduction polynomial 0x11B. xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 0x1B : 0).
- Latency is exactly 2 cycles from input handshake to out_valid when no stall occurs.
- Throughput is 1 beat/cycle.
- Stall rules:
  - s2_en = !s2_valid || out_ready.
  - s1_en = !s1_valid || s2_en.
  - in_ready = s1_en.
- Capacity is two beats; beats leave in the order they arrived.
- out_data and out_valid hold stable while out_valid && !out_ready.
- Simultaneous output pop and input push when full: both occur in the same cycle with no bubble and no loss.
- sc and in_last are sampled per beat, so mixed encrypt/decrypt beats may be interleaved back to back.
- Control (valid) registers are reset; data registers are reset only per ZERO_DATA_ON_RESET.

Optional Feature:
- Macro: AES_ROUND_TAG_EN.
- Defined:
  - Adds ports in_tag (in, 4) and out_tag (out, 4).
  - The tag travels with its beat through both stages and carries the round number.
  - out_tag resets to 0 and holds stable under stall exactly like out_data.
- Undefined: the ports are absent and no tag registers are built.

Test Plan:
- sc=0, in_last=0, in_data=d42711aee0bf98f1b8b45de51e415230, in_key=a0fafe1788542cb123a339392a6c7605, out_ready=1 -> out_valid 2 cycles later with out_data=a49c7ff2689f352b6b5bea43026a5049.
- sc=0, in_last=1, same data and key -> out_data=7445a32768e07e1f9be228c8344beee0.
- sc=1, in_last=0, in_data=a49c7ff2689f352b6b5bea43026a5049, same key -> out_data=d42711aee0bf98f1b8b45de51e415230.
- Backpressure: stream 4 beats with out_ready=0 -> in_ready drops after 2 accepted beats and out_data holds. Then release out_ready -> all 4 beats emerge in order with correct values and no duplicates.
- Interleaved: alternate sc=0/sc=1 on consecutive cycles with out_ready=1 -> each output matches its own mode, at 1 result/cycle.
- Assert rst with 2 beats in flight -> out_valid=0 immediately and in_ready=1. After release, no stale beat appears and a new beat completes with 2-cycle latency.

Source files
------------

// File: rtl/aes_round_tail.sv
// ---------------------------------------------------------------------------
// aes_round_tail
//
// Two-stage pipelined AES round back-end. It sits behind the 16-byte SubBytes
// array and finishes the round:
//   encrypt (sc=0): ShiftRows -> MixColumns (skipped when last) -> AddRoundKey
//   decrypt (sc=1): AddRoundKey -> InvMixColumns (skipped when last) -> InvShiftRows
//
// Stage 1 does the cheap byte permutation (encrypt) or the key XOR (decrypt).
// Stage 2 does the column mixing and the remaining half of the round.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   sc         direction per beat: 0 = encrypt, 1 = decrypt
//   in_valid   input beat valid
//   in_ready   stage can accept a beat (combinational)
//   in_data    SubBytes output, byte 0 = [127:120], column-major
//              (byte k = row k%4, column k/4)
//   in_key     round key, same byte order
//   in_last    final round: skip (Inv)MixColumns
//   in_tag     round number tag (only with AES_ROUND_TAG_EN)
//   out_tag    tag of the beat on out_data (only with AES_ROUND_TAG_EN)
//   out_valid  result valid
//   out_ready  downstream accepts
//   out_data   round result
//
// Handshake: a beat moves across an interface on the rising clock edge where
// valid && ready are both high. A producer holding valid low may change its
// data freely; out_valid/out_data (and out_tag) stay stable while out_valid is
// high and out_ready is low. Capacity is two beats, delivered in order.
//
// Parameters
//   DW                  state/key width, must be 128
//   ZERO_DATA_ON_RESET  1: data registers clear on reset; 0: only control clears
//
// Optional feature macro: AES_ROUND_TAG_EN (adds in_tag/out_tag, 4 bits each,
// carried alongside each beat through both stages).
// ---------------------------------------------------------------------------
module aes_round_tail #(
    parameter int DW                 = 128,
    parameter int ZERO_DATA_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sc,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [DW-1:0] in_key,
    input  logic          in_last,
`ifdef AES_ROUND_TAG_EN
    input  logic [3:0]    in_tag,
    output logic [3:0]    out_tag,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    // The byte shuffles below are written for a 128-bit state only.
    generate
        if (DW != 128) begin : g_bad_dw
            $error("aes_round_tail: DW must be 128");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // GF(2^8) helpers, reduction polynomial 0x11B
    // -----------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // MixColumns on one column {a0,a1,a2,a3}, a0 in the top byte.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] x0, x1, x2, x3;
        {a0, a1, a2, a3} = col;
        x0 = xtime(a0);
        x1 = xtime(a1);
        x2 = xtime(a2);
        x3 = xtime(a3);
        return {x0 ^ x1 ^ a1 ^ a2 ^ a3,
                a0 ^ x1 ^ x2 ^ a2 ^ a3,
                a0 ^ a1 ^ x2 ^ x3 ^ a3,
                x0 ^ a0 ^ a1 ^ a2 ^ x3};
    endfunction

    // InvMixColumns on one column. Coefficients 9/11/13/14 are built from the
    // doubling chain 2a, 4a, 8a:
    //   9a = 8a^a, 11a = 8a^2a^a, 13a = 8a^4a^a, 14a = 8a^4a^2a
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [3:0][7:0] a;
        logic [3:0][7:0] m2, m4, m8;
        logic [3:0][7:0] m9, m11, m13, m14;
        a = col;
        for (int i = 0; i < 4; i++) begin
            m2[i]  = xtime(a[i]);
            m4[i]  = xtime(m2[i]);
            m8[i]  = xtime(m4[i]);
            m9[i]  = m8[i] ^ a[i];
            m11[i] = m8[i] ^ m2[i] ^ a[i];
            m13[i] = m8[i] ^ m4[i] ^ a[i];
            m14[i] = m8[i] ^ m4[i] ^ m2[i];
        end
        // a[3] is row 0 of the column (top byte), a[0] is row 3.
        return {m14[3] ^ m11[2] ^ m13[1] ^ m9[0],
                m9[3]  ^ m14[2] ^ m11[1] ^ m13[0],
                m13[3] ^ m9[2]  ^ m14[1] ^ m11[0],
                m11[3] ^ m13[2] ^ m9[1]  ^ m14[0]};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [3:0][31:0] c;
        logic [3:0][31:0] m;
        c = s;
        for (int i = 0; i < 4; i++) begin
            m[i] = mix_col(c[i]);
        end
        return m;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [3:0][31:0] c;
        logic [3:0][31:0] m;
        c = s;
        for (int i = 0; i < 4; i++) begin
            m[i] = inv_mix_col(c[i]);
        end
        return m;
    endfunction

    // -----------------------------------------------------------------------
    // Row rotations. With the packed view b = s, state byte k lives in
    // b[15-k]; byte k sits at row k%4, column k/4.
    // -----------------------------------------------------------------------
    // Row r rotates left by r columns: out(r,c) = in(r,(c+r)%4).
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [15:0][7:0] b;
        b = s;
        return {b[15], b[10], b[5],  b[0],
                b[11], b[6],  b[1],  b[12],
                b[7],  b[2],  b[13], b[8],
                b[3],  b[14], b[9],  b[4]};
    endfunction

    // Row r rotates right by r columns: out(r,c) = in(r,(c-r)%4).
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [15:0][7:0] b;
        b = s;
        return {b[15], b[2],  b[5],  b[8],
                b[11], b[14], b[1],  b[4],
                b[7],  b[10], b[13], b[0],
                b[3],  b[6],  b[9],  b[12]};
    endfunction

    // -----------------------------------------------------------------------
    // Pipeline control
    // -----------------------------------------------------------------------
    logic         r_s1_valid;
    logic         r_s1_last;
    logic         r_s1_sc;
    logic [127:0] r_s1_data;
    logic [127:0] r_s1_key;
    logic         r_s2_valid;
    logic [127:0] r_s2_data;

    logic         w_s1_en;
    logic         w_s2_en;
    logic         w_in_fire;
    logic         w_s2_load;

    // Each stage may advance when it is empty or when the stage after it is
    // advancing, so a full pipe still moves one beat per cycle under out_ready.
    assign w_s2_en   = !r_s2_valid || out_ready;
    assign w_s1_en   = !r_s1_valid || w_s2_en;
    assign in_ready  = w_s1_en;
    assign w_in_fire = in_valid && w_s1_en;
    assign w_s2_load = w_s2_en && r_s1_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_sc    <= 1'b0;
        end else begin
            if (w_s1_en) begin
                r_s1_valid <= in_valid;
            end
            if (w_s2_en) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_in_fire) begin
                r_s1_last <= in_last;
                r_s1_sc   <= sc;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    logic [127:0] w_s1_next;
    logic [127:0] w_enc_mix;
    logic [127:0] w_enc_out;
    logic [127:0] w_dec_mix;
    logic [127:0] w_dec_out;
    logic [127:0] w_s2_next;

    // Stage 1: encrypt permutes bytes, decrypt removes the round key.
    assign w_s1_next = sc ? (in_data ^ in_key) : shift_rows(in_data);

    // Stage 2: the key is only still needed on the encrypt path.
    assign w_enc_mix = r_s1_last ? r_s1_data : mix_columns(r_s1_data);
    assign w_enc_out = w_enc_mix ^ r_s1_key;
    assign w_dec_mix = r_s1_last ? r_s1_data : inv_mix_columns(r_s1_data);
    assign w_dec_out = inv_shift_rows(w_dec_mix);
    assign w_s2_next = r_s1_sc ? w_dec_out : w_enc_out;

    generate
        if (ZERO_DATA_ON_RESET != 0) begin : g_data_rst
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s1_data <= '0;
                    r_s1_key  <= '0;
                    r_s2_data <= '0;
                end else begin
                    if (w_in_fire) begin
                        r_s1_data <= w_s1_next;
                        r_s1_key  <= in_key;
                    end
                    if (w_s2_load) begin
                        r_s2_data <= w_s2_next;
                    end
                end
            end
        end else begin : g_data_norst
            always_ff @(posedge clk) begin
                if (w_in_fire) begin
                    r_s1_data <= w_s1_next;
                    r_s1_key  <= in_key;
                end
                if (w_s2_load) begin
                    r_s2_data <= w_s2_next;
                end
            end
        end
    endgenerate

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;

`ifdef AES_ROUND_TAG_EN
    // Tag follows its beat with the same load enables as the data.
    logic [3:0] r_s1_tag;
    logic [3:0] r_s2_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_tag <= 4'd0;
            r_s2_tag <= 4'd0;
        end else begin
            if (w_in_fire) begin
                r_s1_tag <= in_tag;
            end
            if (w_s2_load) begin
                r_s2_tag <= r_s1_tag;
            end
        end
    end

    assign out_tag = r_s2_tag;
`endif

endmodule

// File: tb/tb_aes_round_tail.sv
module tb_aes_round_tail;

  localparam logic [127:0] KEY   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] SB    = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] E_MIX = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] E_LST = 128'h7445a32768e07e1f9be228c8344beee0;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         sc = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [127:0] in_key = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;

  aes_round_tail dut (
    .clk       (clk),
    .rst       (rst),
    .sc        (sc),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // scoreboard
  logic [127:0] exp_q[$];
  logic [127:0] cur_exp = '0;
  int errors = 0;
  int checks = 0;
  int pops = 0;
  logic last_in_fire = 1'b0;
  logic prev_stall = 1'b0;
  logic [127:0] prev_data = '0;

  // reference model: byte (r,c) at bit 127-8*(4c+r)
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int r, input int c);
    return s[127 - 8*(4*c + r) -: 8];
  endfunction

  // coefs: row-0 coefficients, top byte first; row r uses them rotated right by r
  function automatic logic [127:0] mix_model(input logic [127:0] t, input logic [31:0] coefs);
    logic [127:0] u;
    logic [7:0] acc;
    logic [7:0] cf;
    u = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          cf = coefs[31 - 8*((j - r + 4) % 4) -: 8];
          acc = acc ^ gmul(cf, gb(t, j, c));
        end
        u[127 - 8*(4*c + r) -: 8] = acc;
      end
    end
    return u;
  endfunction

  function automatic logic [127:0] model(input logic m_sc, input logic m_last,
                                         input logic [127:0] d, input logic [127:0] k);
    logic [127:0] t;
    logic [127:0] u;
    logic [127:0] o;
    t = '0;
    o = '0;
    if (!m_sc) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[127 - 8*(4*c + r) -: 8] = gb(d, r, (c + r) % 4);
      u = m_last ? t : mix_model(t, 32'h02030101);
      o = u ^ k;
    end else begin
      t = d ^ k;
      u = m_last ? t : mix_model(t, 32'h0e0b0d09);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          o[127 - 8*(4*c + r) -: 8] = gb(u, r, (c - r + 4) % 4);
    end
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic s, input logic l, input logic [127:0] d,
                       input logic [127:0] k, input logic [127:0] e);
    in_valid = 1'b1;
    sc = s;
    in_last = l;
    in_data = d;
    in_key = k;
    cur_exp = e;
  endtask

  task automatic drive_rand(input logic s, input logic l);
    logic [127:0] d;
    logic [127:0] k;
    d = rand128();
    k = rand128();
    drive(s, l, d, k, model(s, l, d, k));
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // One clock: called in the low phase with inputs set; samples just before
  // the rising edge, then returns at the following falling edge.
  task automatic tick();
    logic [127:0] e;
    #1;
    if (prev_stall) begin
      chk("hold_valid", {127'd0, out_valid}, 128'd1);
      chk("hold_data", out_data, prev_data);
    end
    last_in_fire = in_valid && in_ready;
    if (last_in_fire) exp_q.push_back(cur_exp);
    if (out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_out observed=%h expected=none", out_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        pops++;
        chk("out_data", out_data, e);
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data = out_data;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int acc;
    int p0;
    int sent;
    logic pending;
    logic [127:0] bp_d;

    // reset state
    rst = 1'b1;
    out_ready = 1'b1;
    idle();
    #2;
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {127'd0, in_ready}, 128'd1);

    // encrypt middle round, latency 2
    drive(1'b0, 1'b0, SB, KEY, E_MIX);
    tick();
    idle();
    #1;
    chk("lat1_out_valid", {127'd0, out_valid}, 128'd0);
    tick();
    #1;
    chk("lat2_out_valid", {127'd0, out_valid}, 128'd1);
    tick();

    // encrypt last round, then decrypt middle round back to back
    drive(1'b0, 1'b1, SB, KEY, E_LST);
    tick();
    drive(1'b1, 1'b0, E_MIX, KEY, SB);
    tick();
    idle();
    repeat (3) tick();
    chk("directed_pops", pops, 3);

    // backpressure: 4 beats with out_ready low
    out_ready = 1'b0;
    p0 = pops;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      bp_d = rand128();
      drive(1'b0, acc[0], bp_d, KEY, model(1'b0, acc[0], bp_d, KEY));
      tick();
      if (last_in_fire) acc++;
    end
    #1;
    chk("bp_accepted", acc, 2);
    chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
    chk("bp_no_output", pops - p0, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && acc < 4; i++) begin
      if (!last_in_fire || i == 0) begin
        bp_d = rand128();
        drive(1'b1, acc[0], bp_d, KEY, model(1'b1, acc[0], bp_d, KEY));
      end
      tick();
      if (last_in_fire) acc++;
    end
    idle();
    repeat (4) tick();
    chk("bp_all_accepted", acc, 4);
    chk("bp_drained", pops - p0, 4);

    // interleaved encrypt/decrypt at full rate
    p0 = pops;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      drive_rand(i[0], ($urandom_range(0, 1) == 1));
      tick();
      if (last_in_fire) acc++;
    end
    idle();
    repeat (2) tick();
    chk("il_accepted", acc, 8);
    chk("il_throughput", pops - p0, 8);

    // reset with two beats in flight
    out_ready = 1'b0;
    drive_rand(1'b0, 1'b0);
    tick();
    drive_rand(1'b1, 1'b0);
    tick();
    idle();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("midrst_in_ready", {127'd0, in_ready}, 128'd1);
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("no_stale_out_valid", {127'd0, out_valid}, 128'd0);
      tick();
    end
    p0 = pops;
    drive(1'b0, 1'b0, SB, KEY, E_MIX);
    tick();
    idle();
    #1;
    chk("rlat1_out_valid", {127'd0, out_valid}, 128'd0);
    tick();
    #1;
    chk("rlat2_out_valid", {127'd0, out_valid}, 128'd1);
    tick();
    chk("rst_new_beat", pops - p0, 1);

    // random traffic with random backpressure
    sent = 0;
    pending = 1'b0;
    for (int i = 0; i < 300 && sent < 16; i++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      if (!pending && $urandom_range(0, 3) != 0) begin
        drive_rand(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
        pending = 1'b1;
      end
      tick();
      if (last_in_fire) begin
        sent++;
        pending = 1'b0;
        idle();
      end
    end
    idle();
    out_ready = 1'b1;
    repeat (6) tick();
    chk("rand_sent", sent, 16);
    chk("end_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
